// File: rtl/branch_resolver_pkg.sv
// Shared branch types: funct3 codes, XLEN, and the condition evaluator used by branch_resolver.
package branch_resolver_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_e;

  typedef struct packed {
    logic taken;
    logic illegal;
  } br_cond_t;

  // Flags describe a - b computed as a + ~b + 1, so c=1 means a >= b unsigned.
  function automatic br_cond_t br_eval(input logic [2:0] funct3,
                                       input logic n, input logic z,
                                       input logic c, input logic v);
    br_cond_t r;
    r = '0;
    case (funct3)
      BEQ:     r.taken = z;
      BNE:     r.taken = !z;
      BLT:     r.taken = n ^ v;
      BGE:     r.taken = !(n ^ v);
      BLTU:    r.taken = !c;
      BGEU:    r.taken = c;
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Handshake and payload bundle for branch_resolver; slave is the resolver side, master the driver side.
interface branch_resolver_if
  import branch_resolver_pkg::*;
#(
  parameter int unsigned N = XLEN
) ();

  logic         in_valid;
  logic         in_ready;
  logic [2:0]   funct3;
  logic         n;
  logic         z;
  logic         c;
  logic         v;
  logic [N-1:0] pc;
  logic [N-1:0] imm;
  logic         out_valid;
  logic         out_ready;
  logic         taken;
  logic [N-1:0] target;
  logic         illegal;
  logic [31:0]  taken_cnt;
  logic [31:0]  total_cnt;

  modport slave (
    input  in_valid, funct3, n, z, c, v, pc, imm, out_ready,
    output in_ready, out_valid, taken, target, illegal, taken_cnt, total_cnt
  );

  modport master (
    output in_valid, funct3, n, z, c, v, pc, imm, out_ready,
    input  in_ready, out_valid, taken, target, illegal, taken_cnt, total_cnt
  );

endinterface

// File: rtl/branch_resolver_skid_buffer.sv
// Generic two-entry pipeline stage: output register plus one skid entry, registered in_ready.
module skid_buffer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         in_ready_q;
  logic         accept;
  logic         drain;

  assign accept = in_valid_i && in_ready_q;
  assign drain  = out_valid_q && out_ready_i;

  // in_ready_q mirrors !skid_valid_q, so accept never coincides with a full skid.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_data_d = in_data_i;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/branch_resolver.sv
// Resolves branch condition and target with a 1-cycle skid-buffered pipeline.
// Optional statistics counters enabled by macro BRANCH_RESOLVER_STATS_EN.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned N = XLEN
) (
  input logic               clk,
  input logic               rst,
  branch_resolver_if.slave  bus
);

  localparam int unsigned W = N + 2;

  br_cond_t     cond;
  logic [N-1:0] tgt;
  logic [W-1:0] in_data;
  logic [W-1:0] out_data;

  always_comb begin
    cond = br_eval(bus.funct3, bus.n, bus.z, bus.c, bus.v);
    tgt  = bus.pc + bus.imm;
  end

  assign in_data = {cond.taken, cond.illegal, tgt};

  skid_buffer #(
    .W(W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (in_data),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (out_data)
  );

  assign bus.taken   = out_data[W-1];
  assign bus.illegal = out_data[W-2];
  assign bus.target  = out_data[N-1:0];

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] taken_cnt_q;
  logic [31:0] total_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_cnt_q <= '0;
      total_cnt_q <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      total_cnt_q <= total_cnt_q + 32'd1;
      taken_cnt_q <= taken_cnt_q + {31'd0, bus.taken};
    end
  end

  assign bus.taken_cnt = taken_cnt_q;
  assign bus.total_cnt = total_cnt_q;
`else
  assign bus.taken_cnt = '0;
  assign bus.total_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed vectors, queue of expected results, negedge monitor.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  localparam int unsigned N = XLEN;

  typedef struct packed {
    logic         taken;
    logic         illegal;
    logic [N-1:0] target;
  } exp_t;

  typedef struct packed {
    logic [2:0]   f3;
    logic         n;
    logic         z;
    logic         c;
    logic         v;
    logic [N-1:0] pc;
    logic [N-1:0] imm;
    exp_t         exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolver_if #(.N(N)) bus ();

  branch_resolver #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic        b2b_en = 1'b0;
  int          b2b_pops = 0;
  int unsigned b2b_first = 0;
  int unsigned b2b_last = 0;
  vec_t        vt[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      got.taken   = bus.taken;
      got.illegal = bus.illegal;
      got.target  = bus.target;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got=%0b/%0b/%h required=none",
                 got.taken, got.illegal, got.target);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL result taken/illegal/target got=%0b/%0b/%h required=%0b/%0b/%h",
                   got.taken, got.illegal, got.target, e.taken, e.illegal, e.target);
        end
      end
      if (b2b_en) begin
        if (b2b_pops == 0) b2b_first = cyc;
        b2b_last = cyc;
        b2b_pops++;
      end
    end
  end

  function automatic vec_t mk(input logic [2:0] f3, input logic n, input logic z,
                              input logic c, input logic v, input logic [N-1:0] pc,
                              input logic [N-1:0] imm, input logic t, input logic il,
                              input logic [N-1:0] tgt);
    vec_t r;
    r.f3 = f3; r.n = n; r.z = z; r.c = c; r.v = v;
    r.pc = pc; r.imm = imm;
    r.exp.taken = t; r.exp.illegal = il; r.exp.target = tgt;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  // Drives one item and holds it until accepted; payload is scrambled once in_valid drops.
  task automatic offer(input vec_t vv);
    bus.in_valid = 1'b1;
    bus.funct3 = vv.f3; bus.n = vv.n; bus.z = vv.z; bus.c = vv.c; bus.v = vv.v;
    bus.pc = vv.pc; bus.imm = vv.imm;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(vv.exp);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.funct3 = 3'b010; bus.pc = '1; bus.imm = '1;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout got=in_ready_low required=accept");
    bus.in_valid = 1'b0;
  endtask

  task automatic drain_wait();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = mk(3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'hF8);
    vt[1] = mk(3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2000, 32'h10, 1'b0, 1'b0, 32'h2010);
    vt[2] = mk(3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h20, 1'b1, 1'b0, 32'h60);
    vt[3] = mk(3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1000, 32'h4, 1'b0, 1'b1, 32'h1004);
    vt[4] = mk(3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h20, 1'b0, 1'b0, 32'h10);
    vt[5] = mk(3'b101, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    vt[6] = mk(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h8, 1'b1, 1'b0, 32'h10);
    vt[7] = mk(3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h8000_0000);

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.funct3 = '0; bus.n = 1'b0; bus.z = 1'b0; bus.c = 1'b0; bus.v = 1'b0;
    bus.pc = '0; bus.imm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_taken", 64'(bus.taken), 64'd0);
    check("rst_illegal", 64'(bus.illegal), 64'd0);
    check("rst_target", 64'(bus.target), 64'd0);
    check("rst_taken_cnt", 64'(bus.taken_cnt), 64'd0);
    check("rst_total_cnt", 64'(bus.total_cnt), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      offer(vt[i]);
      check("latency_out_valid", 64'(bus.out_valid), 64'd1);
      drain_wait();
    end

    b2b_en = 1'b1;
    for (int i = 0; i < 8; i++) offer(vt[i]);
    drain_wait();
    b2b_en = 1'b0;
    check("b2b_count", 64'(b2b_pops), 64'd8);
    check("b2b_span", 64'(b2b_last - b2b_first), 64'd7);

    bus.out_ready = 1'b0;
    offer(vt[4]);
    offer(vt[5]);
    @(negedge clk);
    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    check("stall_out_valid", 64'(bus.out_valid), 64'd1);
    check("stall_target", 64'(bus.target), 64'(vt[4].exp.target));
    fork
      offer(vt[6]);
      begin
        @(posedge clk);
        #1;
        check("stall_hold_target", 64'(bus.target), 64'(vt[4].exp.target));
        bus.out_ready = 1'b1;
      end
    join
    drain_wait();

    bus.out_ready = 1'b0;
    offer(vt[0]);
    offer(vt[1]);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_target", 64'(bus.target), 64'd0);
    check("midrst_total_cnt", 64'(bus.total_cnt), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) offer(vt[i]);
    drain_wait();
    @(posedge clk);
    #1;
`ifdef BRANCH_RESOLVER_STATS_EN
    check("total_cnt", 64'(bus.total_cnt), 64'd4);
    check("taken_cnt", 64'(bus.taken_cnt), 64'd2);
`else
    check("total_cnt", 64'(bus.total_cnt), 64'd0);
    check("taken_cnt", 64'(bus.taken_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
